nf10_axilite_rd_arbiter: RTL and testbench
==========================================

Name: nf10_axilite_rd_arbiter

Overview:
- Two-master AXI4-Lite read-channel arbiter sharing one register slave, e.g. the nf10_identifier ID/version block.
- Host (PCIe DMA register path, master 0) and MicroBlaze (master 1) both read it.
- Round-robin grant, one outstanding read at a time. Address latched, response buffered back to the winning master.
- Write channels are not routed through this block; the slave's write path is wired separately.

Parameters:
- C_S_AXI_ADDR_WIDTH, 32, address width of every master and the slave.
- C_S_AXI_DATA_WIDTH, 32, read data width.
- C_NUM_MASTERS, 2, number of requesters. Only 2 is supported; any other value is an elaboration error.

Ports:
- S_AXI_ACLK  in  1  single clock for all ports.
- S_AXI_ARESET  in  1  synchronous, active-high reset.
- S_AXI_ARADDR  in  2*ADDR  master i address in bits [i*ADDR +: ADDR].
- S_AXI_ARVALID  in  2  per-master read request.
- S_AXI_ARREADY  out  2  per-master address accept.
- S_AXI_RDATA  out  2*DATA  per-master read data.
- S_AXI_RRESP  out  4  per-master response, 2 bits each.
- S_AXI_RVALID  out  2  per-master data valid.
- S_AXI_RREADY  in  2  per-master data accept.
- M_AXI_ARADDR  out  ADDR  to slave.
- M_AXI_ARVALID  out  1  to slave.
- M_AXI_ARREADY  in  1  from slave.
- M_AXI_RDATA  in  DATA  from slave.
- M_AXI_RRESP  in  2  from slave.
- M_AXI_RVALID  in  1  from slave.
- M_AXI_RREADY  out  1  to slave.

Behaviour:
- The FSM has 4 states: IDLE, ADDR, DATA, RESP. Registers: state, grant (1 bit), rr_ptr (1 bit), addr_q, data_q, resp_q.
- Reset (synchronous, S_AXI_ARESET=1 at a clock edge):
  - state=IDLE, rr_ptr=0, grant=0, addr_q/data_q/resp_q=0.
  - All S_AXI_ARREADY, S_AXI_RVALID, M_AXI_ARVALID and M_AXI_RREADY are 0.
  - S_AXI_RDATA and S_AXI_RRESP are 0.
  - Reset mid-transaction abandons the transaction silently. The slave shares the same reset.
- IDLE:
  - Winner = rr_ptr if ARVALID[rr_ptr], else the other master if its ARVALID is set.
  - S_AXI_ARREADY[winner] is combinational, high only in IDLE when a winner exists. Exactly one ARREADY is high per accepted request.
  - On acceptance: addr_q <= ARADDR[winner], grant <= winner, state -> ADDR.
  - With no request, stay in IDLE.
- ADDR:
  - M_AXI_ARVALID=1, M_AXI_ARADDR=addr_q.
  - ARVALID and ARADDR are held stable until M_AXI_ARREADY. On that handshake, state -> DATA.
  - Minimum latency from master accept to slave ARVALID is 1 cycle.
- DATA:
  - M_AXI_RREADY=1.
  - On M_AXI_RVALID: data_q <= RDATA, resp_q <= RRESP, state -> RESP.
  - M_AXI_RREADY is 0 in every other state.
- RESP:
  - S_AXI_RVALID[grant]=1; S_AXI_RDATA/RRESP of slot grant = data_q/resp_q.
  - The held values stay stable until S_AXI_RREADY[grant].
  - On that handshake: rr_ptr <= ~grant, state -> IDLE.
  - The non-granted master's RVALID stays 0 and its data/resp slot is 0.
- Minimum round trip is 4 cycles (IDLE accept, ADDR, DATA, RESP) with a zero-wait slave and RREADY held high. The next grant comes in the cycle after the RESP handshake.
- Both ARVALIDs asserted in the same IDLE cycle: rr_ptr wins, and the loser is served next. Continuous requests alternate 0,1,0,1.
- A master may not drop ARVALID before ARREADY (AXI rule). The block does not need to tolerate violations.
- SLVERR/DECERR responses from the slave are forwarded unchanged.
- RRESP from slave is passed through even if it has no data meaning; no retry is performed.

Test Plan:
- Reset, then master 0 reads 0x6a000000, slave returns 0x4E463130/OKAY with zero wait -> S_AXI_ARREADY[0] high in cycle 0, M_AXI_ARVALID in cycle 1, S_AXI_RVALID[0] with 0x4E463130 in cycle 3. Master 1 outputs stay 0 throughout.
- Both masters assert ARVALID in the same cycle after reset, addresses 0x6a000004 and 0x6a000008 -> master 0 served first and master 1 second. M_AXI_ARADDR sequence is 0x6a000004 then 0x6a000008.
- Both masters request continuously for 6 transactions -> grants alternate 0,1,0,1,0,1 and no master is served twice in a row.
- Slave holds ARREADY low 5 cycles, then delays RVALID 7 cycles -> M_AXI_ARVALID/ARADDR stay stable through the stall and M_AXI_RREADY is high only in DATA. The correct data reaches the granted master.
- Master 1 holds RREADY low 10 cycles while master 0 asserts ARVALID -> RVALID[1] and data stay stable, S_AXI_ARREADY[0] stays 0 until the master 1 handshake, then master 0 is accepted in the next cycle.
- Assert S_AXI_ARESET while in DATA -> next cycle all outputs are 0 and state is IDLE. A new master 1 request is then accepted normally with rr_ptr=0 arbitration.

Source files
------------

// File: rtl/nf10_axilite_rd_arbiter_if.sv
// AXI4-Lite read-channel bundle for the two-master register arbiter.
// Upstream masters sit on the S_AXI_* side, the shared register slave on M_AXI_*.
interface nf10_axilite_rd_arbiter_if #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_NUM_MASTERS      = 2
);
  logic [C_NUM_MASTERS*C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR;
  logic [C_NUM_MASTERS-1:0]                    S_AXI_ARVALID;
  logic [C_NUM_MASTERS-1:0]                    S_AXI_ARREADY;
  logic [C_NUM_MASTERS*C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA;
  logic [C_NUM_MASTERS*2-1:0]                  S_AXI_RRESP;
  logic [C_NUM_MASTERS-1:0]                    S_AXI_RVALID;
  logic [C_NUM_MASTERS-1:0]                    S_AXI_RREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]               M_AXI_ARADDR;
  logic                                        M_AXI_ARVALID;
  logic                                        M_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]               M_AXI_RDATA;
  logic [1:0]                                  M_AXI_RRESP;
  logic                                        M_AXI_RVALID;
  logic                                        M_AXI_RREADY;

  // Environment view: drives requests and the slave's responses.
  modport master (
    output S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY
  );

  // Arbiter view.
  modport slave (
    input  S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY
  );
endinterface

// File: rtl/nf10_axilite_rd_arbiter.sv
// Round-robin two-master AXI4-Lite read arbiter, one outstanding read at a time.
// Address is latched on accept; the slave's response is buffered back to the winner.
module nf10_axilite_rd_arbiter #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_NUM_MASTERS      = 2
) (
  input logic S_AXI_ACLK,
  input logic S_AXI_ARESET,
  nf10_axilite_rd_arbiter_if.slave bus
);
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;

  generate
    if (C_NUM_MASTERS != 2) begin : g_bad_num_masters
      $error("nf10_axilite_rd_arbiter supports exactly 2 masters");
    end
  endgenerate

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  logic [1:0]    r_state;
  logic          r_grant;
  logic          r_rr_ptr;
  logic [AW-1:0] r_addr_q;
  logic [DW-1:0] r_data_q;
  logic [1:0]    r_resp_q;

  logic          w_win;
  logic          w_accept;
  logic [AW-1:0] w_win_addr;
  logic [1:0]    w_arready;
  logic [1:0]    w_rvalid;
  logic [2*DW-1:0] w_rdata;
  logic [3:0]    w_rresp;

  // rr_ptr has priority; otherwise fall to the other master.
  assign w_win      = bus.S_AXI_ARVALID[r_rr_ptr] ? r_rr_ptr : ~r_rr_ptr;
  assign w_accept   = (r_state == ST_IDLE) && !S_AXI_ARESET && (|bus.S_AXI_ARVALID[1:0]);
  assign w_win_addr = bus.S_AXI_ARADDR[w_win*AW +: AW];

  always_comb begin
    w_arready = '0;
    w_rvalid  = '0;
    w_rdata   = '0;
    w_rresp   = '0;
    for (int i = 0; i < 2; i++) begin
      w_arready[i] = w_accept && (w_win == 1'(i));
      if ((r_state == ST_RESP) && (r_grant == 1'(i))) begin
        w_rvalid[i]         = 1'b1;
        w_rdata[i*DW +: DW] = r_data_q;
        w_rresp[i*2 +: 2]   = r_resp_q;
      end
    end
  end

  assign bus.S_AXI_ARREADY = w_arready;
  assign bus.S_AXI_RVALID  = w_rvalid;
  assign bus.S_AXI_RDATA   = w_rdata;
  assign bus.S_AXI_RRESP   = w_rresp;
  assign bus.M_AXI_ARADDR  = r_addr_q;
  assign bus.M_AXI_ARVALID = (r_state == ST_ADDR);
  assign bus.M_AXI_RREADY  = (r_state == ST_DATA);

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_state  <= ST_IDLE;
      r_grant  <= 1'b0;
      r_rr_ptr <= 1'b0;
      r_addr_q <= '0;
      r_data_q <= '0;
      r_resp_q <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_addr_q <= w_win_addr;
          r_grant  <= w_win;
          r_state  <= ST_ADDR;
        end
        ST_ADDR: if (bus.M_AXI_ARREADY) r_state <= ST_DATA;
        ST_DATA: if (bus.M_AXI_RVALID) begin
          r_data_q <= bus.M_AXI_RDATA;
          r_resp_q <= bus.M_AXI_RRESP;
          r_state  <= ST_RESP;
        end
        ST_RESP: if (bus.S_AXI_RREADY[r_grant]) begin
          r_rr_ptr <= ~r_grant;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nf10_axilite_rd_arbiter.sv
// Directed bench for the two-master AXI4-Lite read arbiter.
// Inputs change 1ns after posedge; outputs are sampled on the falling edge.
module tb_nf10_axilite_rd_arbiter;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  nf10_axilite_rd_arbiter_if #(.C_S_AXI_ADDR_WIDTH(32), .C_S_AXI_DATA_WIDTH(32), .C_NUM_MASTERS(2)) bif ();

  nf10_axilite_rd_arbiter #(
    .C_S_AXI_ADDR_WIDTH(32), .C_S_AXI_DATA_WIDTH(32), .C_NUM_MASTERS(2)
  ) dut (
    .S_AXI_ACLK  (clk),
    .S_AXI_ARESET(rst),
    .bus         (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bif.S_AXI_ARADDR  = '0;
    bif.S_AXI_ARVALID = '0;
    bif.S_AXI_RREADY  = 2'b11;
    bif.M_AXI_ARREADY = 1'b1;
    bif.M_AXI_RDATA   = '0;
    bif.M_AXI_RRESP   = '0;
    bif.M_AXI_RVALID  = 1'b1;
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  // One read for master m against a zero-wait slave; starts in IDLE with ARVALID[m] up.
  task automatic xact(input int m, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] r, input bit drop);
    logic [1:0]  exp_sel;
    logic [63:0] exp_data;
    logic [3:0]  exp_resp;
    exp_sel  = 2'b01 << m;
    exp_data = {32'h0, d} << (m * 32);
    exp_resp = {2'b00, r} << (m * 2);
    bif.M_AXI_RDATA = d;
    bif.M_AXI_RRESP = r;
    @(negedge clk);
    total++; if (bif.S_AXI_ARREADY !== exp_sel) begin bad++;
      $display("FAIL xact_arready m=%0d got=%b exp=%b", m, bif.S_AXI_ARREADY, exp_sel); end
    total++; if (bif.M_AXI_ARVALID !== 1'b0) begin bad++;
      $display("FAIL xact_idle_marvalid got=%b exp=0", bif.M_AXI_ARVALID); end
    nxt();
    if (drop) bif.S_AXI_ARVALID[m] = 1'b0;
    @(negedge clk);
    total++; if (bif.M_AXI_ARVALID !== 1'b1 || bif.M_AXI_ARADDR !== a) begin bad++;
      $display("FAIL xact_addr m=%0d got=%b/%h exp=1/%h", m, bif.M_AXI_ARVALID, bif.M_AXI_ARADDR, a); end
    total++; if (bif.S_AXI_ARREADY !== 2'b00) begin bad++;
      $display("FAIL xact_addr_arready got=%b exp=00", bif.S_AXI_ARREADY); end
    nxt();
    @(negedge clk);
    total++; if (bif.M_AXI_RREADY !== 1'b1 || bif.S_AXI_RVALID !== 2'b00) begin bad++;
      $display("FAIL xact_data got rready=%b rvalid=%b exp 1/00", bif.M_AXI_RREADY, bif.S_AXI_RVALID); end
    nxt();
    @(negedge clk);
    total++; if (bif.S_AXI_RVALID !== exp_sel) begin bad++;
      $display("FAIL xact_rvalid m=%0d got=%b exp=%b", m, bif.S_AXI_RVALID, exp_sel); end
    total++; if (bif.S_AXI_RDATA !== exp_data || bif.S_AXI_RRESP !== exp_resp) begin bad++;
      $display("FAIL xact_rdata m=%0d got=%h/%b exp=%h/%b", m, bif.S_AXI_RDATA, bif.S_AXI_RRESP, exp_data, exp_resp); end
    total++; if (bif.M_AXI_RREADY !== 1'b0 || bif.S_AXI_ARREADY !== 2'b00) begin bad++;
      $display("FAIL xact_resp_ctrl got rready=%b arready=%b exp 0/00", bif.M_AXI_RREADY, bif.S_AXI_ARREADY); end
    nxt();
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    bif.S_AXI_ARVALID = 2'b11;
    @(negedge clk);
    total++; if (bif.S_AXI_ARREADY !== 2'b00 || bif.S_AXI_RVALID !== 2'b00 ||
                 bif.M_AXI_ARVALID !== 1'b0 || bif.M_AXI_RREADY !== 1'b0) begin bad++;
      $display("FAIL reset_ctrl got arready=%b rvalid=%b marvalid=%b mrready=%b exp all 0",
               bif.S_AXI_ARREADY, bif.S_AXI_RVALID, bif.M_AXI_ARVALID, bif.M_AXI_RREADY); end
    total++; if (bif.S_AXI_RDATA !== 64'h0 || bif.S_AXI_RRESP !== 4'h0 || bif.M_AXI_ARADDR !== 32'h0) begin bad++;
      $display("FAIL reset_data got rdata=%h rresp=%b araddr=%h exp 0", bif.S_AXI_RDATA, bif.S_AXI_RRESP, bif.M_AXI_ARADDR); end
    nxt();
    rst = 1'b0;
    bif.S_AXI_ARVALID = 2'b00;
  endtask

  task automatic test_single();
    do_reset();
    bif.S_AXI_ARADDR[31:0] = 32'h6a000000;
    bif.S_AXI_ARVALID = 2'b01;
    xact(0, 32'h6a000000, 32'h4E463130, 2'b00, 1'b1);
  endtask

  task automatic test_both();
    do_reset();
    bif.S_AXI_ARADDR  = {32'h6a000008, 32'h6a000004};
    bif.S_AXI_ARVALID = 2'b11;
    xact(0, 32'h6a000004, 32'h11110000, 2'b00, 1'b1);
    xact(1, 32'h6a000008, 32'h22220001, 2'b00, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    bif.S_AXI_ARADDR  = {32'h6a000010, 32'h6a000014};
    bif.S_AXI_ARVALID = 2'b11;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) xact(0, 32'h6a000014, 32'hA0000000 + k, 2'b10, 1'b0);
      else            xact(1, 32'h6a000010, 32'hB0000000 + k, 2'b11, 1'b0);
    end
    bif.S_AXI_ARVALID = 2'b00;
  endtask

  task automatic test_slave_stall();
    do_reset();
    bif.M_AXI_ARREADY = 1'b0;
    bif.M_AXI_RVALID  = 1'b0;
    bif.S_AXI_ARADDR  = {32'h6a00001C, 32'h0};
    bif.S_AXI_ARVALID = 2'b10;
    @(negedge clk);
    total++; if (bif.S_AXI_ARREADY !== 2'b10) begin bad++;
      $display("FAIL stall_accept got=%b exp=10", bif.S_AXI_ARREADY); end
    nxt();
    bif.S_AXI_ARVALID = 2'b00;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) bif.M_AXI_ARREADY = 1'b1;
      @(negedge clk);
      total++; if (bif.M_AXI_ARVALID !== 1'b1 || bif.M_AXI_ARADDR !== 32'h6a00001C || bif.M_AXI_RREADY !== 1'b0) begin bad++;
        $display("FAIL stall_addr k=%0d got=%b/%h/%b exp=1/6a00001c/0", k, bif.M_AXI_ARVALID, bif.M_AXI_ARADDR, bif.M_AXI_RREADY); end
      nxt();
    end
    bif.M_AXI_ARREADY = 1'b0;
    bif.M_AXI_RDATA   = 32'hCAFE0042;
    bif.M_AXI_RRESP   = 2'b10;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) bif.M_AXI_RVALID = 1'b1;
      @(negedge clk);
      total++; if (bif.M_AXI_RREADY !== 1'b1 || bif.M_AXI_ARVALID !== 1'b0 || bif.S_AXI_RVALID !== 2'b00) begin bad++;
        $display("FAIL stall_data k=%0d got rready=%b marvalid=%b rvalid=%b exp 1/0/00", k, bif.M_AXI_RREADY, bif.M_AXI_ARVALID, bif.S_AXI_RVALID); end
      nxt();
    end
    bif.M_AXI_RVALID = 1'b0;
    bif.M_AXI_RDATA  = 32'hDEADDEAD;
    @(negedge clk);
    total++; if (bif.S_AXI_RVALID !== 2'b10 || bif.S_AXI_RDATA !== {32'hCAFE0042, 32'h0} ||
                 bif.S_AXI_RRESP !== 4'b1000 || bif.M_AXI_RREADY !== 1'b0) begin bad++;
      $display("FAIL stall_resp got %b/%h/%b exp 10/cafe004200000000/1000", bif.S_AXI_RVALID, bif.S_AXI_RDATA, bif.S_AXI_RRESP); end
    nxt();
  endtask

  task automatic test_rready_stall();
    do_reset();
    bif.S_AXI_RREADY  = 2'b01;
    bif.S_AXI_ARADDR  = {32'h6a000020, 32'h6a000024};
    bif.S_AXI_ARVALID = 2'b10;
    bif.M_AXI_RDATA   = 32'h5A5A1234;
    bif.M_AXI_RRESP   = 2'b01;
    nxt();
    bif.S_AXI_ARVALID = 2'b01;
    nxt();
    nxt();
    bif.M_AXI_RDATA = 32'h0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++; if (bif.S_AXI_RVALID !== 2'b10 || bif.S_AXI_RDATA !== {32'h5A5A1234, 32'h0} ||
                   bif.S_AXI_RRESP !== 4'b0100 || bif.S_AXI_ARREADY !== 2'b00) begin bad++;
        $display("FAIL rready_hold k=%0d got %b/%h/%b arready=%b", k, bif.S_AXI_RVALID, bif.S_AXI_RDATA, bif.S_AXI_RRESP, bif.S_AXI_ARREADY); end
      nxt();
    end
    bif.S_AXI_RREADY = 2'b11;
    nxt();
    @(negedge clk);
    total++; if (bif.S_AXI_ARREADY !== 2'b01 || bif.S_AXI_RVALID !== 2'b00) begin bad++;
      $display("FAIL rready_next_grant got arready=%b rvalid=%b exp 01/00", bif.S_AXI_ARREADY, bif.S_AXI_RVALID); end
    nxt();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bif.M_AXI_RVALID  = 1'b0;
    bif.S_AXI_ARADDR  = {32'h6a000030, 32'h6a000034};
    bif.S_AXI_ARVALID = 2'b01;
    nxt();
    bif.S_AXI_ARVALID = 2'b00;
    nxt();
    @(negedge clk);
    total++; if (bif.M_AXI_RREADY !== 1'b1) begin bad++;
      $display("FAIL midrst_in_data got=%b exp=1", bif.M_AXI_RREADY); end
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    bif.M_AXI_RVALID = 1'b1;
    @(negedge clk);
    total++; if (bif.S_AXI_ARREADY !== 2'b00 || bif.S_AXI_RVALID !== 2'b00 || bif.M_AXI_ARVALID !== 1'b0 ||
                 bif.M_AXI_RREADY !== 1'b0 || bif.S_AXI_RDATA !== 64'h0 || bif.M_AXI_ARADDR !== 32'h0) begin bad++;
      $display("FAIL midrst_outputs got arready=%b rvalid=%b marvalid=%b mrready=%b rdata=%h araddr=%h",
               bif.S_AXI_ARREADY, bif.S_AXI_RVALID, bif.M_AXI_ARVALID, bif.M_AXI_RREADY, bif.S_AXI_RDATA, bif.M_AXI_ARADDR); end
    nxt();
    bif.S_AXI_ARVALID = 2'b10;
    xact(1, 32'h6a000030, 32'h0BADF00D, 2'b00, 1'b1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    test_reset();
    test_single();
    test_both();
    test_back_to_back();
    test_slave_stall();
    test_rready_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
